// File: rtl/pgi_pkg.sv
// pulse_gap_inserter shared constants and counter-width helper.
// Optional frame strobe is controlled by macro PGI_FRAME_STB_EN.
package pgi_pkg;

  localparam int PGI_CH_DEF        = 4;
  localparam int PGI_FRAME_LEN_DEF = 40;
  localparam int PGI_GAP_LEN_DEF   = 1;

  // Width of a counter holding 0 .. n-1; never narrower than one bit.
  function automatic int pgi_cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pgi_edge_det.sv
// Two-stage synchronizer plus one-cycle-delayed copy for falling-edge detect.
// Part of pulse_gap_inserter (see PGI_FRAME_STB_EN in the top).
module pgi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_s,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_p;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end

  assign o_s    = r_s2;
  assign o_fall = r_p & ~r_s2;

endmodule

// File: rtl/pulse_gap_inserter.sv
// Per-channel frame counter that blanks the last GAP_LEN pulses of each frame.
// Define PGI_FRAME_STB_EN to build the per-channel frame-wrap strobe.
module pulse_gap_inserter
  import pgi_pkg::*;
#(
  parameter  int CH        = PGI_CH_DEF,
  parameter  int FRAME_LEN = PGI_FRAME_LEN_DEF,
  parameter  int GAP_LEN   = PGI_GAP_LEN_DEF,
  localparam int CW        = pgi_cw(FRAME_LEN)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [CH-1:0]  pulse_in,
  output logic [CH-1:0]  pulse_out,
  output logic [CH-1:0]  frame_stb,
  output logic [CH*CW-1:0] frame_cnt
);

  if (FRAME_LEN < 2 || GAP_LEN < 1 || GAP_LEN >= FRAME_LEN) begin : g_bad_param
    $error("pulse_gap_inserter: need FRAME_LEN>=2 and 1<=GAP_LEN<FRAME_LEN");
  end

  localparam logic [CW-1:0] LAST      = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] GAP_START = CW'(FRAME_LEN - GAP_LEN);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic          w_s;
    logic          w_fall;
    logic          w_gap;
    logic          w_wrap;
    logic [CW-1:0] r_cnt;
    logic          r_po;

    pgi_edge_det u_det (
      .clk    (clk),
      .rst    (rst),
      .i_d    (pulse_in[k]),
      .o_s    (w_s),
      .o_fall (w_fall)
    );

    assign w_wrap = w_fall && (r_cnt == LAST);
    assign w_gap  = en && (r_cnt >= GAP_START);

    // Disable clears the count every cycle, so it also wins over a wrap.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (!en) begin
        r_cnt <= '0;
      end else if (w_fall) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_po <= 1'b0;
      end else begin
        r_po <= w_s & ~w_gap;
      end
    end

    assign pulse_out[k]            = r_po;
    assign frame_cnt[k*CW +: CW]   = r_cnt;

`ifdef PGI_FRAME_STB_EN
    logic r_stb;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_stb <= 1'b0;
      end else begin
        r_stb <= en & w_wrap;
      end
    end

    assign frame_stb[k] = r_stb;
`endif
  end

`ifndef PGI_FRAME_STB_EN
  assign frame_stb = '0;
`endif

endmodule

// File: tb/tb_pulse_gap_inserter.sv
// Bench for pulse_gap_inserter: default 4-channel instance plus a
// FRAME_LEN=10/GAP_LEN=3 single-channel instance, checked every cycle.
module tb_pulse_gap_inserter;

`ifdef PGI_FRAME_STB_EN
  localparam int STB_ON = 1;
`else
  localparam int STB_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  pin;
  logic [0:0]  pin_b;
  logic [3:0]  po_a;
  logic [3:0]  stb_a;
  logic [23:0] cnt_a;
  logic [0:0]  po_b;
  logic [0:0]  stb_b;
  logic [3:0]  cnt_b;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pulse_gap_inserter u_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pulse_in  (pin),
    .pulse_out (po_a),
    .frame_stb (stb_a),
    .frame_cnt (cnt_a)
  );

  pulse_gap_inserter #(
    .CH        (1),
    .FRAME_LEN (10),
    .GAP_LEN   (3)
  ) u_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pulse_in  (pin_b),
    .pulse_out (po_b),
    .frame_stb (stb_b),
    .frame_cnt (cnt_b)
  );

  // Model: lanes 0..3 are u_a channels, lane 4 is u_b.
  // Each lane keeps the sampled input history; the synchronized level
  // seen in cycle n is the input sampled two edges earlier.
  bit hin [5][16384];
  int mcnt [5];
  bit mpo  [5];
  bit mstb [5];
  int cyc     = 0;
  int lastrst = -1;
  bit chk_on  = 0;

  function automatic bit lane_in(input int l);
    return (l == 4) ? pin_b[0] : pin[l];
  endfunction

  function automatic bit past(input int l, input int m);
    if (m < 0 || m <= lastrst) return 1'b0;
    return hin[l][m];
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < 5; l++) begin
      int f;
      int g;
      bit s;
      bit p;
      bit fall;
      f    = (l == 4) ? 10 : 40;
      g    = (l == 4) ? 3 : 1;
      s    = past(l, cyc - 2);
      p    = past(l, cyc - 3);
      fall = p & ~s;
      if (!rst) begin
        mcnt[l] = 0;
        mpo[l]  = 1'b0;
        mstb[l] = 1'b0;
      end else begin
        mpo[l]  = s & ~(en && mcnt[l] >= f - g);
        mstb[l] = en && fall && (mcnt[l] == f - 1);
        if (!en) mcnt[l] = 0;
        else if (fall) mcnt[l] = (mcnt[l] + 1) % f;
      end
      hin[l][cyc] = lane_in(l);
    end
    if (!rst) lastrst = cyc;
    cyc++;
    chk_on = 1'b1;
  end

  logic prev_po [5];
  int   rises   [5];
  int   stbs    [5];

  initial begin
    for (int l = 0; l < 5; l++) begin
      prev_po[l] = 1'b0;
      rises[l]   = 0;
      stbs[l]    = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int l = 0; l < 5; l++) begin
        logic       gp;
        logic       gs;
        logic [5:0] gc;
        logic       es;
        gp = (l == 4) ? po_b[0] : po_a[l];
        gs = (l == 4) ? stb_b[0] : stb_a[l];
        gc = (l == 4) ? {2'b00, cnt_b} : cnt_a[l*6 +: 6];
        es = (STB_ON != 0) ? mstb[l] : 1'b0;
        nvec++;
        if (gp !== mpo[l] || gs !== es || gc !== 6'(mcnt[l])) begin
          nfail++;
          $display("FAIL lane%0d cyc%0d: po=%b/%b stb=%b/%b cnt=%0d/%0d (got/exp)",
                   l, cyc, gp, mpo[l], gs, es, gc, mcnt[l]);
        end
        if (gp === 1'b1 && prev_po[l] !== 1'b1) rises[l]++;
        if (gs === 1'b1) stbs[l]++;
        prev_po[l] = gp;
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic pulses(input int n, input logic [3:0] ma, input int nb);
    for (int i = 0; i < n; i++) begin
      pin   = ma;
      pin_b = (i < nb) ? 1'b1 : 1'b0;
      repeat (2) @(negedge clk);
      pin   = '0;
      pin_b = '0;
      repeat (2) @(negedge clk);
    end
  endtask

  int r0 [5];
  int s0 [5];

  initial begin
    rst   = 1'b0;
    en    = 1'b1;
    pin   = '0;
    pin_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset pulse_out", int'(po_a), 0);
    check("reset frame_cnt", int'(cnt_a), 0);
    check("reset frame_stb", int'(stb_a), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // One full default frame on ch0; 25 pulses into the 10/3 instance.
    r0 = rises;
    s0 = stbs;
    pulses(40, 4'b0001, 25);
    repeat (6) @(negedge clk);
    #1;
    check("ch0 passed pulses", rises[0] - r0[0], 39);
    check("ch0 strobes", stbs[0] - s0[0], STB_ON);
    check("ch0 cnt after frame", int'(cnt_a[5:0]), 0);
    check("ch1 idle pulses", rises[1] - r0[1], 0);
    check("B passed pulses", rises[4] - r0[4], 19);
    check("B cnt after 25", int'(cnt_b), 5);
    check("B strobes", stbs[4] - s0[4], 2 * STB_ON);

    // Disabled: everything passes, counters held at zero.
    en = 1'b0;
    r0 = rises;
    s0 = stbs;
    pulses(50, 4'b1111, 50);
    repeat (6) @(negedge clk);
    #1;
    for (int l = 0; l < 5; l++)
      check($sformatf("en0 lane%0d passed", l), rises[l] - r0[l], 50);
    check("en0 cnt_a", int'(cnt_a), 0);
    check("en0 cnt_b", int'(cnt_b), 0);
    check("en0 strobes", stbs[0] - s0[0] + stbs[4] - s0[4], 0);

    // Enable drops exactly in the wrap cycle on ch1.
    en = 1'b1;
    s0 = stbs;
    pulses(39, 4'b0010, 0);
    pin = 4'b0010;
    repeat (2) @(negedge clk);
    pin = '0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("wrap+dis ch1 strobes", stbs[1] - s0[1], 0);
    check("wrap+dis ch1 cnt", int'(cnt_a[11:6]), 0);

    // Reset mid-frame on ch2 with a pulse spanning reset release.
    pulses(17, 4'b0100, 0);
    pin = 4'b0100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("midrst pulse_out", int'(po_a), 0);
    check("midrst cnt", int'(cnt_a), 0);
    rst = 1'b1;
    pin = '0;
    repeat (4) @(negedge clk);
    r0 = rises;
    pulses(23, 4'b0100, 0);
    repeat (4) @(negedge clk);
    #1;
    check("post-rst 23 passed", rises[2] - r0[2], 23);
    check("post-rst cnt 23", int'(cnt_a[17:12]), 23);
    pulses(17, 4'b0100, 0);
    repeat (6) @(negedge clk);
    #1;
    check("post-rst 40 passed", rises[2] - r0[2], 39);
    check("post-rst cnt wrap", int'(cnt_a[17:12]), 0);

    // Different rates on every channel, edges coinciding at times.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    r0 = rises;
    s0 = stbs;
    for (int c = 0; c < 240; c++) begin
      for (int k = 0; k < 4; k++) pin[k] = ((c / (k + 1)) % 2) == 0;
      pin_b = pin[0];
      @(negedge clk);
    end
    pin   = '0;
    pin_b = '0;
    repeat (6) @(negedge clk);
    #1;
    check("rates ch0 cnt", int'(cnt_a[5:0]), 0);
    check("rates ch1 cnt", int'(cnt_a[11:6]), 20);
    check("rates ch2 cnt", int'(cnt_a[17:12]), 0);
    check("rates ch3 cnt", int'(cnt_a[23:18]), 30);
    check("rates B cnt", int'(cnt_b), 0);
    check("rates ch0 passed", rises[0] - r0[0], 117);
    check("rates B passed", rises[4] - r0[4], 84);
    check("rates ch0 strobes", stbs[0] - s0[0], 3 * STB_ON);
    check("rates ch2 strobes", stbs[2] - s0[2], STB_ON);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
